// File: rtl/flipper_ball_collision_pkg.sv
// Shared flipper constants, Q10 trig tables and small helpers used by the
// flipper motion generator and the ball/flipper collision block.
package flipper_pkg;

  localparam int SHIFT_VALUE = 10;
  localparam int XC          = 185;
  localparam int YC          = 400;
  localparam int R           = 80;
  localparam int HIT_DIST    = 12;
  localparam int KICK        = 32;
  localparam int VMAX        = 255;

  typedef logic signed [10:0] vel_t;

  typedef enum logic [2:0] {
    IDLE, LATCH, TRIG, PROJ, CHECK, VDECOMP, VROT, DONE
  } state_t;

  // round(1024*sin(deg)) for 0..90; cos comes from the mirrored index
  localparam logic [10:0] SIN_Q10 [0:90] = '{
    11'd0,    11'd18,   11'd36,   11'd54,   11'd71,   11'd89,   11'd107,  11'd125,
    11'd143,  11'd160,  11'd178,  11'd195,  11'd213,  11'd230,  11'd248,  11'd265,
    11'd282,  11'd299,  11'd316,  11'd333,  11'd350,  11'd367,  11'd384,  11'd400,
    11'd416,  11'd433,  11'd449,  11'd465,  11'd481,  11'd496,  11'd512,  11'd527,
    11'd543,  11'd558,  11'd573,  11'd587,  11'd602,  11'd616,  11'd630,  11'd644,
    11'd658,  11'd672,  11'd685,  11'd698,  11'd711,  11'd724,  11'd737,  11'd749,
    11'd761,  11'd773,  11'd784,  11'd796,  11'd807,  11'd818,  11'd828,  11'd839,
    11'd849,  11'd859,  11'd868,  11'd878,  11'd887,  11'd896,  11'd904,  11'd912,
    11'd920,  11'd928,  11'd935,  11'd943,  11'd949,  11'd956,  11'd962,  11'd968,
    11'd974,  11'd979,  11'd984,  11'd989,  11'd994,  11'd998,  11'd1002, 11'd1005,
    11'd1008, 11'd1011, 11'd1014, 11'd1016, 11'd1018, 11'd1020, 11'd1022, 11'd1023,
    11'd1023, 11'd1024, 11'd1024
  };

  function automatic logic [10:0] sin_q10(input logic [6:0] a);
    return SIN_Q10[int'(a)];
  endfunction

  function automatic logic [10:0] cos_q10(input logic [6:0] a);
    return SIN_Q10[90 - int'(a)];
  endfunction

  function automatic vel_t sat_vel(input logic signed [25:0] v);
    if (v > 26'(VMAX))       return vel_t'(VMAX);
    else if (v < -26'(VMAX)) return vel_t'(-VMAX);
    else                     return v[10:0];
  endfunction

endpackage

// File: rtl/flipper_ball_collision_if.sv
// Frame-rate request/response bundle between the frame logic and the
// collision block: ball state and flipper angle in, velocity result out.
interface flipper_ball_collision_if;
  import flipper_pkg::*;

  logic        SOF;
  logic [10:0] ball_X;
  logic [10:0] ball_Y;
  vel_t        ball_Vx;
  logic [6:0]  alpha;
  vel_t        ball_Vy;
  logic        move;
  logic        done;
  logic        hit;
  vel_t        new_Vx;
  vel_t        new_Vy;

  modport master (
    output SOF, ball_X, ball_Y, ball_Vx, ball_Vy, alpha, move,
    input  done, hit, new_Vx, new_Vy
  );

  modport slave (
    input  SOF, ball_X, ball_Y, ball_Vx, ball_Vy, alpha, move,
    output done, hit, new_Vx, new_Vy
  );

endinterface

// File: rtl/flipper_ball_collision_trig_rom.sv
// Registered Q10 cos/sin lookup; one-cycle latency, angles above 90 read 90.
module trig_rom
  import flipper_pkg::*;
(
  input  logic       clk,
  input  logic [6:0] angle,
  output logic [10:0] cos_q,
  output logic [10:0] sin_q
);

  logic [6:0]  idx;
  logic [10:0] cos_d, sin_d;

  always_comb begin
    idx   = (angle > 7'd90) ? 7'd90 : angle;
    cos_d = cos_q10(idx);
    sin_d = sin_q10(idx);
  end

  always_ff @(posedge clk) begin
    cos_q <= cos_d;
    sin_q <= sin_d;
  end

endmodule

// File: rtl/flipper_ball_collision.sv
// Per-frame ball/flipper contact test and velocity reflection, built around
// one shared 12x12 multiplier and a fixed 16-cycle schedule.
module flipper_ball_collision
  import flipper_pkg::*;
(
  input  logic clk,
  input  logic reset,
  flipper_ball_collision_if.slave bus
);

  typedef logic signed [11:0] op_t;
  typedef logic signed [25:0] acc_t;

  localparam op_t KICK_S = 12'(KICK);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  vel_t       vx_q, vx_d, vy_q, vy_d;
  logic [6:0] alpha_q, alpha_d;
  logic       move_q, move_d;
  op_t        dx_q, dx_d, dy_q, dy_d;
  acc_t       acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic       contact_q, contact_d;
  logic       hit_q, hit_d;
  op_t        vt_q, vt_d, vnp_q, vnp_d;
  logic       done_q, done_d, hit_out_q, hit_out_d;
  vel_t       new_vx_q, new_vx_d, new_vy_q, new_vy_d;

  logic [10:0] cos_r, sin_r;

  trig_rom u_rom (
    .clk   (clk),
    .angle (alpha_q),
    .cos_q (cos_r),
    .sin_q (sin_r)
  );

  op_t                cos_s, sin_s, mul_a, mul_b, vt_w, vn_w;
  logic signed [23:0] prod;
  acc_t               prod_x, acc_a_sh, acc_b_sh;
  logic               kick;

  always_comb begin
    cos_s    = {1'b0, cos_r};
    sin_s    = {1'b0, sin_r};
    acc_a_sh = acc_a_q >>> SHIFT_VALUE;
    acc_b_sh = acc_b_q >>> SHIFT_VALUE;
    vt_w     = acc_a_sh[11:0];
    vn_w     = acc_b_sh[11:0];
    kick     = move_q && (alpha_q != 7'd0);
  end

  // Each 4-cycle phase: k0/k1 build acc_a, k2/k3 build acc_b
  always_comb begin
    mul_a = dx_q;
    mul_b = cos_s;
    case (state_q)
      PROJ: begin
        case (k_q)
          2'd0:    begin mul_a = dx_q; mul_b = cos_s; end
          2'd1:    begin mul_a = dy_q; mul_b = sin_s; end
          2'd2:    begin mul_a = dy_q; mul_b = cos_s; end
          default: begin mul_a = dx_q; mul_b = sin_s; end
        endcase
      end
      VDECOMP: begin
        case (k_q)
          2'd0:    begin mul_a = {vx_q[10], vx_q}; mul_b = cos_s; end
          2'd1:    begin mul_a = {vy_q[10], vy_q}; mul_b = sin_s; end
          2'd2:    begin mul_a = {vy_q[10], vy_q}; mul_b = cos_s; end
          default: begin mul_a = {vx_q[10], vx_q}; mul_b = sin_s; end
        endcase
      end
      VROT: begin
        // k0 reads vt straight from the accumulator; vt_q/vnp_q are loaded on that same edge
        case (k_q)
          2'd0:    begin mul_a = vt_w;  mul_b = cos_s; end
          2'd1:    begin mul_a = vnp_q; mul_b = sin_s; end
          2'd2:    begin mul_a = vt_q;  mul_b = sin_s; end
          default: begin mul_a = vnp_q; mul_b = cos_s; end
        endcase
      end
      default: ;
    endcase
    prod   = mul_a * mul_b;
    prod_x = {{2{prod[23]}}, prod};
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    alpha_d   = alpha_q;
    move_d    = move_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    contact_d = contact_q;
    hit_d     = hit_q;
    vt_d      = vt_q;
    vnp_d     = vnp_q;
    done_d    = 1'b0;
    hit_out_d = 1'b0;
    new_vx_d  = new_vx_q;
    new_vy_d  = new_vy_q;

    case (state_q)
      IDLE: if (bus.SOF) state_d = LATCH;

      LATCH: begin
        vx_d    = bus.ball_Vx;
        vy_d    = bus.ball_Vy;
        alpha_d = (bus.alpha > 7'd90) ? 7'd90 : bus.alpha;
        move_d  = bus.move;
        dx_d    = {1'b0, bus.ball_X} - 12'(XC);
        dy_d    = {1'b0, bus.ball_Y} - 12'(YC);
        state_d = TRIG;
      end

      TRIG: begin
        k_d     = 2'd0;
        state_d = PROJ;
      end

      PROJ, VDECOMP, VROT: begin
        case (k_q)
          2'd0:    acc_a_d = prod_x;
          2'd1:    acc_a_d = (state_q == VROT) ? acc_a_q - prod_x : acc_a_q + prod_x;
          2'd2:    acc_b_d = prod_x;
          default: acc_b_d = (state_q == VROT) ? acc_b_q + prod_x : acc_b_q - prod_x;
        endcase
        if (state_q == VROT && k_q == 2'd0) begin
          hit_d = contact_q && (vn_w > 12'sd0);
          vt_d  = vt_w;
          vnp_d = hit_d ? (-vn_w - (kick ? KICK_S : 12'sd0)) : vn_w;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (state_q == PROJ)         state_d = CHECK;
          else if (state_q == VDECOMP) state_d = VROT;
          else                         state_d = DONE;
        end
      end

      CHECK: begin
        contact_d = (acc_a_sh >= 26'sd0) && (acc_a_sh <= acc_t'(R)) &&
                    (acc_b_sh >= -acc_t'(HIT_DIST)) && (acc_b_sh <= 26'sd0);
        k_d       = 2'd0;
        state_d   = VDECOMP;
      end

      DONE: begin
        done_d    = 1'b1;
        hit_out_d = hit_q;
        new_vx_d  = hit_q ? sat_vel(acc_a_sh) : vx_q;
        new_vy_d  = hit_q ? sat_vel(acc_b_sh) : vy_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      alpha_q   <= '0;
      move_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      contact_q <= 1'b0;
      hit_q     <= 1'b0;
      vt_q      <= '0;
      vnp_q     <= '0;
      done_q    <= 1'b0;
      hit_out_q <= 1'b0;
      new_vx_q  <= '0;
      new_vy_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      alpha_q   <= alpha_d;
      move_q    <= move_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      contact_q <= contact_d;
      hit_q     <= hit_d;
      vt_q      <= vt_d;
      vnp_q     <= vnp_d;
      done_q    <= done_d;
      hit_out_q <= hit_out_d;
      new_vx_q  <= new_vx_d;
      new_vy_q  <= new_vy_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.hit    = hit_out_q;
  assign bus.new_Vx = new_vx_q;
  assign bus.new_Vy = new_vy_q;

endmodule

// File: tb/tb_flipper_ball_collision.sv
// Directed frames with hand-computed Q10 results, plus SOF re-pulse and
// mid-frame reset cases.
module tb_flipper_ball_collision;
  import flipper_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  flipper_ball_collision_if bus();

  flipper_ball_collision dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int a, input bit mv, input int x, input int y,
                       input int vx, input int vy);
    bus.alpha   = 7'(a);
    bus.move    = mv;
    bus.ball_X  = 11'(x);
    bus.ball_Y  = 11'(y);
    bus.ball_Vx = 11'(vx);
    bus.ball_Vy = 11'(vy);
  endtask

  // One frame: SOF sampled on edge 0, done expected after edge 16
  task automatic run_frame(input string tag, input int a, input bit mv,
                           input int x, input int y, input int vx, input int vy,
                           input bit scramble,
                           input int e_hit, input int e_vx, input int e_vy);
    int n;
    @(negedge clk);
    drive(a, mv, x, y, vx, vy);
    bus.SOF = 1'b1;
    @(posedge clk); #1;
    bus.SOF = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 3) drive(45, ~mv, 0, 0, -300, -300);
    end
    chk({tag, ".lat"}, n, 16);
    chk({tag, ".hit"}, int'(bus.hit), e_hit);
    chk({tag, ".vx"},  int'(bus.new_Vx), e_vx);
    chk({tag, ".vy"},  int'(bus.new_Vy), e_vy);
    @(posedge clk); #1;
    chk({tag, ".done_lo"}, int'(bus.done), 0);
    chk({tag, ".vy_hold"}, int'(bus.new_Vy), e_vy);
  endtask

  initial begin
    int cnt, first;
    reset   = 1'b1;
    bus.SOF = 1'b0;
    drive(0, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.done", int'(bus.done), 0);
    chk("rst.hit",  int'(bus.hit), 0);
    chk("rst.vx",   int'(bus.new_Vx), 0);
    chk("rst.vy",   int'(bus.new_Vy), 0);
    @(negedge clk);
    reset = 1'b0;

    //        tag         alpha mv  x    y    vx   vy  scr hit  e_vx  e_vy
    run_frame("flat",      0,   0, 225, 390,   0,  64, 0,  1,    0,  -64);
    run_frame("endstop",   0,   1, 225, 390,   0,  64, 0,  1,    0,  -64);
    run_frame("swing",    20,   1, 224, 409,   0,  64, 1,  1,   51,  -80);
    run_frame("miss_tip",  0,   0, 275, 395,  10,  20, 0,  0,   10,   20);
    run_frame("away",      0,   0, 225, 392,   0, -30, 0,  0,    0,  -30);
    run_frame("tip_edge",  0,   0, 265, 395,   0,  40, 0,  1,    0,  -40);
    run_frame("too_high",  0,   0, 225, 387,   0,  40, 0,  0,    0,   40);
    run_frame("clamp90", 100,   0, 190, 440, -64,   0, 0,  1,   64,    0);
    run_frame("sat",       1,   1, 225, 390,   0, 250, 0,  1,    8, -255);

    // SOF re-pulsed while busy must be dropped
    @(negedge clk);
    drive(0, 1'b0, 225, 390, 0, 64);
    bus.SOF = 1'b1;
    @(posedge clk); #1;
    bus.SOF = 1'b0;
    cnt = 0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) bus.SOF = 1'b1;
      if (i == 6) bus.SOF = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("repulse.cnt", cnt, 1);
    chk("repulse.lat", first, 16);

    // make the held outputs nonzero, then reset mid-frame
    run_frame("pre_rst",   1,   1, 225, 390,   0, 250, 0,  1,    8, -255);
    @(negedge clk);
    drive(0, 1'b0, 225, 390, 0, 64);
    bus.SOF = 1'b1;
    @(posedge clk); #1;
    bus.SOF = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.done", int'(bus.done), 0);
    chk("midrst.hit",  int'(bus.hit), 0);
    chk("midrst.vx",   int'(bus.new_Vx), 0);
    chk("midrst.vy",   int'(bus.new_Vy), 0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) cnt++;
    end
    chk("midrst.no_done", cnt, 0);

    run_frame("recover",   0,   0, 225, 390,   0,  64, 0,  1,    0,  -64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
